// File: rtl/lsu_pkg.sv
// lsu_pkg: shared access-size type and lane helpers for the load/store port
package lsu_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

    function automatic logic [7:0] be_mask(size_e size, logic [2:0] off);
        return size == SZ_B ? 8'h01 << off :
               size == SZ_H ? 8'h03 << off :
               size == SZ_W ? 8'h0F << off : 8'hFF;
    endfunction

    // Works on a 64-bit view; 32-bit callers truncate the result.
    function automatic logic [63:0] extract(logic [63:0] rdata, size_e size, logic sext, logic [2:0] off);
        logic [63:0] s;
        s = rdata >> {off, 3'b000};
        return size == SZ_B ? {{56{sext & s[7]}}, s[7:0]} :
               size == SZ_H ? {{48{sext & s[15]}}, s[15:0]} :
               size == SZ_W ? {{32{sext & s[31]}}, s[31:0]} : s;
    endfunction

endpackage

// File: rtl/lsu_tag_fifo.sv
// lsu_tag_fifo: in-order tag store for outstanding loads
module lsu_tag_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] cnt;
    logic          push_ok, pop_ok;

    assign full    = cnt == CW'(DEPTH);
    assign empty   = cnt == '0;
    assign push_ok = push & !full;
    assign pop_ok  = pop & !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (pop_ok) rptr <= rptr + 1'b1;
            cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: pipelined load/store port with in-order responses, posted stores and drain
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REG_W     = 5,
    parameter int MAX_OUTST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m_valid,
    input  logic                m_wr,
    input  logic [1:0]          m_size,
    input  logic                m_sext,
    input  logic [ADDR_W-1:0]   m_addr,
    input  logic [DATA_W-1:0]   m_wdata,
    input  logic [REG_W-1:0]    m_rd,
    output logic                m_stall,
    output logic                misalign,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                wb_valid,
    output logic [REG_W-1:0]    wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    input  logic                drain_req,
    output logic                drain_done
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int TAG_W = REG_W + 3 + OFF_W;

    size_e             sz;
    logic              legal, full, empty, push, pop, t_sx;
    logic [OFF_W-1:0]  off, t_off;
    logic [TAG_W-1:0]  tag;
    logic [REG_W-1:0]  t_rd;
    logic [1:0]        t_sz;

    assign sz    = size_e'(m_size);
    assign off   = m_addr[OFF_W-1:0];
    assign legal = sz == SZ_B
                || (sz == SZ_H && !m_addr[0])
                || (sz == SZ_W && m_addr[1:0] == 2'b00)
                || (sz == SZ_D && DATA_W == 64 && m_addr[2:0] == 3'b000);

    // A full tag FIFO blocks loads even when a response pops this cycle.
    assign bus_req  = m_valid & legal & !drain_req & !(!m_wr & full);
    assign m_stall  = m_valid & legal & !(bus_req & bus_gnt);
    assign misalign = m_valid & !legal;
    assign bus_we   = bus_req & m_wr;
    assign bus_addr = {m_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign bus_be   = bus_req ? BE_W'(be_mask(sz, 3'(off))) : '0;
    assign bus_wdata = sz == SZ_B ? {BE_W{m_wdata[7:0]}} :
                       sz == SZ_H ? {(BE_W/2){m_wdata[15:0]}} :
                       sz == SZ_W ? {(DATA_W/32){m_wdata[31:0]}} : m_wdata;

    assign push = bus_req & bus_gnt & !m_wr;
    assign pop  = bus_rvalid & !empty;
    assign {t_rd, t_sz, t_sx, t_off} = tag;

    lsu_tag_fifo #(.W(TAG_W), .DEPTH(MAX_OUTST)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({m_rd, m_size, m_sext, off}),
        .dout  (tag),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            drain_done <= 1'b0;
        end else begin
            wb_valid   <= pop;
            drain_done <= drain_req & empty & !wb_valid;
            if (pop) begin
                wb_rd   <= t_rd;
                wb_data <= DATA_W'(extract(64'(bus_rdata), size_e'(t_sz), t_sx, 3'(t_off)));
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed and random checks of lsu_mem_port against a queue-based model
module tb_lsu_mem_port;
    localparam int DW = 32, AW = 32, RW = 5, MO = 4;

    logic          clk = 0, rst_n = 0;
    logic          m_valid = 0, m_wr = 0, m_sext = 0;
    logic [1:0]    m_size = 0;
    logic [AW-1:0] m_addr = 0;
    logic [DW-1:0] m_wdata = 0;
    logic [RW-1:0] m_rd = 0;
    logic          m_stall, misalign, bus_req, bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [3:0]    bus_be;
    logic          bus_gnt = 0, bus_rvalid = 0;
    logic [DW-1:0] bus_rdata = 0;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          drain_req = 0, drain_done;

    lsu_mem_port #(.DATA_W(DW), .ADDR_W(AW), .REG_W(RW), .MAX_OUTST(MO)) dut (
        .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_wr(m_wr), .m_size(m_size),
        .m_sext(m_sext), .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd),
        .m_stall(m_stall), .misalign(misalign), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .drain_req(drain_req), .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] rd;
        int            nb;
        bit            sx;
        int            off;
    } tag_t;

    tag_t          q[$];
    logic          e_wbv = 0, e_dd = 0;
    logic [RW-1:0] e_wbrd = 0;
    logic [DW-1:0] e_wbd = 0;
    int            total = 0, bad = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Mask the addressed bytes, then sign-fill above the top byte if requested.
    function automatic logic [DW-1:0] ext(logic [DW-1:0] rd, int nb, bit sx, int off);
        logic [DW-1:0] v, m;
        m = (nb >= 4) ? '1 : ((32'd1 << (nb * 8)) - 32'd1);
        v = (rd >> (off * 8)) & m;
        if (sx && nb < 4 && v[nb*8-1]) v = v | ~m;
        return v;
    endfunction

    task automatic clear_model();
        q.delete();
        e_wbv = 0; e_dd = 0; e_wbrd = 0; e_wbd = 0;
    endtask

    // Check one cycle against the model, then advance the model across the clock edge.
    task automatic cyc();
        int nb, off;
        bit legal, req, stall, mis, pop, ndd;
        logic [3:0]    e_be;
        logic [DW-1:0] e_wd;
        tag_t t;
        #1;
        nb    = 1 << m_size;
        off   = int'(m_addr[1:0]);
        legal = m_size != 2'd3 && (m_addr & (nb - 1)) == 0;
        req   = m_valid && legal && !drain_req && !(!m_wr && q.size() == MO);
        stall = m_valid && legal && !(req && bus_gnt);
        mis   = m_valid && !legal;
        e_be  = 0;
        for (int i = 0; i < 4; i++) begin
            if (req && i >= off && i < off + nb) e_be[i] = 1'b1;
            e_wd[i*8 +: 8] = m_wdata[(i % (nb > 4 ? 4 : nb))*8 +: 8];
        end
        chk("bus_req", bus_req, req);
        chk("m_stall", m_stall, stall);
        chk("misalign", misalign, mis);
        chk("bus_we", bus_we, req && m_wr);
        chk("bus_be", bus_be, e_be);
        if (req) begin
            chk("bus_addr", bus_addr, m_addr & ~32'd3);
            if (m_wr) chk("bus_wdata", bus_wdata, e_wd);
        end
        chk("wb_valid", wb_valid, e_wbv);
        if (e_wbv) begin
            chk("wb_rd", wb_rd, e_wbrd);
            chk("wb_data", wb_data, e_wbd);
        end
        chk("drain_done", drain_done, e_dd);
        @(posedge clk);
        if (!rst_n) clear_model();
        else begin
            pop = bus_rvalid && q.size() > 0;
            ndd = drain_req && q.size() == 0 && !e_wbv;
            e_wbv = pop;
            if (pop) begin
                t = q.pop_front();
                e_wbrd = t.rd;
                e_wbd  = ext(bus_rdata, t.nb, t.sx, t.off);
            end
            if (req && bus_gnt && !m_wr) q.push_back('{rd: m_rd, nb: nb, sx: m_sext, off: off});
            e_dd = ndd;
        end
        #1;
    endtask

    task automatic op(bit v, bit wr, int sz, bit sx, logic [AW-1:0] a, logic [DW-1:0] wd, logic [RW-1:0] rd);
        m_valid = v; m_wr = wr; m_size = 2'(sz); m_sext = sx;
        m_addr = a; m_wdata = wd; m_rd = rd;
    endtask

    task automatic idle();
        op(0, 0, 0, 0, 0, 0, 0);
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    endtask

    initial begin
        clear_model();
        cyc(); cyc();
        rst_n = 1;
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_drain_done", drain_done, 0);
        cyc();

        // word load, response three cycles after grant
        op(1, 0, 2, 0, 'h100, 0, 5); bus_gnt = 1;
        #1 chk("ld_stall", m_stall, 0);
        cyc();
        idle(); cyc(); cyc();
        bus_rvalid = 1; bus_rdata = 'hDEADBEEF; cyc(); bus_rvalid = 0;
        #1;
        chk("ld_wbv", wb_valid, 1);
        chk("ld_wbrd", wb_rd, 5);
        chk("ld_wbd", wb_data, 'hDEADBEEF);
        cyc();

        // byte loads at lane 3, signed and unsigned
        for (int s = 1; s >= 0; s--) begin
            op(1, 0, 0, s[0], 'h103, 0, 7); bus_gnt = 1; cyc();
            idle(); bus_rvalid = 1; bus_rdata = 'h80123456; cyc(); bus_rvalid = 0;
            #1 chk(s ? "lb_sext" : "lb_zext", wb_data, s ? 32'hFFFFFF80 : 32'h00000080);
            cyc();
        end

        // half store at offset 2
        op(1, 1, 1, 0, 'h102, 'h1234, 0); bus_gnt = 1;
        #1;
        chk("sh_addr", bus_addr, 'h100);
        chk("sh_be", bus_be, 4'b1100);
        chk("sh_wdata", bus_wdata, 'h12341234);
        chk("sh_we", bus_we, 1);
        cyc(); idle(); cyc();

        // fill the tag FIFO, fifth load waits until the cycle after a pop
        bus_gnt = 1;
        for (int i = 0; i < 5; i++) begin
            op(1, 0, 2, 0, 'h200 + 4 * i, 0, 5'(i + 1));
            if (i == 4) #1 chk("full_stall", m_stall, 1);
            cyc();
        end
        bus_rvalid = 1; bus_rdata = $urandom;
        #1 chk("full_nobypass", m_stall, 1);
        cyc(); bus_rvalid = 0;
        #1 chk("full_issue", bus_req, 1);
        cyc(); idle();
        for (int i = 0; i < 4; i++) begin
            bus_rvalid = 1; bus_rdata = $urandom; cyc();
        end
        bus_rvalid = 0; cyc();

        // misaligned word and illegal dword
        op(1, 0, 2, 0, 'h101, 0, 3);
        #1;
        chk("mis_pulse", misalign, 1);
        chk("mis_req", bus_req, 0);
        chk("mis_stall", m_stall, 0);
        cyc(); idle(); cyc();
        op(1, 0, 3, 0, 'h100, 0, 3);
        #1 chk("dw_mis", misalign, 1);
        cyc(); idle(); cyc();

        // drain with two loads outstanding
        bus_gnt = 1;
        op(1, 0, 2, 0, 'h300, 0, 9); cyc();
        op(1, 0, 1, 1, 'h306, 0, 10); cyc();
        drain_req = 1; op(1, 1, 2, 0, 'h310, 'hCAFEF00D, 0);
        #1 chk("drain_stall", m_stall, 1);
        cyc();
        bus_rvalid = 1; bus_rdata = 'h11112222; cyc();
        bus_rdata = 'h8000AAAA; cyc(); bus_rvalid = 0;
        cyc(); cyc();
        #1 chk("drain_done_hi", drain_done, 1);
        cyc();
        drain_req = 0; idle(); cyc(); cyc();

        // reset mid-flight, then a late response
        bus_gnt = 1;
        op(1, 0, 2, 0, 'h400, 0, 11); cyc();
        op(1, 0, 2, 0, 'h404, 0, 12); cyc();
        idle(); drain_req = 1;
        rst_n = 0; clear_model(); cyc();
        rst_n = 1; drain_req = 0;
        bus_rvalid = 1; bus_rdata = 'h12345678; cyc(); bus_rvalid = 0;
        #1 chk("late_rvalid", wb_valid, 0);
        cyc();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int sz;
            logic [AW-1:0] a;
            sz = $urandom_range(0, 3);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            op($urandom_range(0, 3) != 0, $urandom_range(0, 1), sz, $urandom_range(0, 1), a, $urandom, 5'($urandom));
            bus_gnt    = $urandom_range(0, 3) != 0;
            bus_rvalid = $urandom_range(0, 2) == 0;
            bus_rdata  = $urandom;
            drain_req  = $urandom_range(0, 15) == 0;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
